// File: rtl/rv_pkg.sv
// Shared RV core types and constants.
// Imported by the fetch stage and its FIFO.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response,
// execute redirect and decode handshake.
interface fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Sync FIFO of fetch entries with flush,
// count, full and empty.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Entry storage; written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, response FIFO.
// `FETCH_MISALIGN_TRAP_EN adds fetch_fault on misaligned redirect.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master fu
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redir_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   out_n;
  logic [CW-1:0]   drop_n;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic            run;
  logic            fault_lock;
  logic            redir;
  logic            rsp;
  logic            req_valid;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign redir = fu.redirect_valid;
  assign rsp   = fu.imem_rsp_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_pc    = fu.redirect_pc;
  assign fetch_fault = fault_lock;

  // Misaligned redirect locks fetch until an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_lock <= 1'b0;
    else if (redir)
      fault_lock <= |fu.redirect_pc[1:0];
  end
`else
  assign redir_pc   = {fu.redirect_pc[XLEN-1:2], 2'b00};
  assign fault_lock = 1'b0;
`endif

  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_valid = run && !redir && !fault_lock
                   && (inflight < (CW+1)'(FIFO_DEPTH));
  assign accept    = req_valid && fu.imem_req_ready;
  assign push      = rsp && !redir && (drop == '0);
  assign pop       = !fifo_empty && fu.instr_ready && !redir;
  assign wr_entry  = '{instr: fu.imem_rsp_data, pc: rsp_pc};

  assign fu.imem_req_valid = req_valid;
  assign fu.imem_req_addr  = fetch_pc;
  assign fu.instr_valid    = !fifo_empty;
  assign fu.instr          = fifo_empty ? INSTR_NOP : head.instr;
  assign fu.instr_pc       = fifo_empty ? rsp_pc : head.pc;

  // Next in-flight and to-be-discarded response counts.
  always_comb begin
    out_n  = outstanding;
    drop_n = drop;
    if (accept) out_n = out_n + CW'(1);
    if (rsp && out_n != '0) out_n = out_n - CW'(1);
    unique case (1'b1)
      redir:
        drop_n = (rsp && outstanding != '0)
               ? outstanding - CW'(1) : outstanding;
      (!redir && rsp && drop != '0):
        drop_n = drop - CW'(1);
      default:
        drop_n = drop;
    endcase
  end

  // PC tracking for requests and for returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= out_n;
      drop        <= drop_n;
      if (redir) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (push)   rsp_pc   <= rsp_pc + PC_STEP;
      end
    end
  end

  // Catch credit bugs and unsolicited memory responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      assert (!(push && fifo_full && !pop));
      assert (!(rsp && outstanding == '0));
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an
// in-order imem model returning addr|1.
module tb_fetch_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fu    (bus.master)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cycle = 0;
  int base;
  int n;
  logic acc_s = 1'b0;
  logic [31:0] addr_s = '0;
  logic [31:0] acc_log [$];
  logic [31:0] aq [$];
  int dq [$];
  fetch_entry_t exp_q [$];
  fetch_entry_t e;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Memory model: capture request mid-cycle, answer at edge.
  always @(negedge clk) begin
    acc_s = rst_n && bus.imem_req_valid && bus.imem_req_ready;
    addr_s = bus.imem_req_addr;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      aq.delete();
      dq.delete();
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data <= '0;
    end else begin
      cycle++;
      if (acc_s) begin
        aq.push_back(addr_s);
        dq.push_back(cycle + lat - 1);
        acc_log.push_back(addr_s);
      end
      if (aq.size() > 0 && dq[0] <= cycle) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data <= aq[0] | 32'h1;
        void'(aq.pop_front());
        void'(dq.pop_front());
      end else begin
        bus.imem_rsp_valid <= 1'b0;
      end
    end
  end

  // Monitor: every decode pop is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready
        && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected none",
                 bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_instr", bus.instr, e.instr);
        chk("pop_pc", bus.instr_pc, e.pc);
      end
    end
  end

  task automatic expect_pop(logic [31:0] pc);
    int k;
    exp_q.push_back('{instr: pc | 32'h1, pc: pc});
    k = 0;
    while (!bus.instr_valid && k < 50) begin
      cyc();
      k++;
    end
    if (!bus.instr_valid) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got no instr expected pc %h", pc);
      void'(exp_q.pop_back());
    end else begin
      bus.instr_ready = 1'b1;
      cyc();
      bus.instr_ready = 1'b0;
    end
  endtask

  task automatic redirect(logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    #1;
    chk("no_req_on_redirect", {31'd0, bus.imem_req_valid}, 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic quiesce(logic [31:0] pc);
    bus.imem_req_ready = 1'b0;
    repeat (8) cyc();
    redirect(pc);
    cyc();
    chk("flushed", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    // Reset release, credit cap, one refill per pop.
    rst_n = 1'b1;
    n = 0;
    while (!bus.imem_req_valid && n < 3) begin
      cyc();
      n++;
    end
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    cyc();
    chk("no_bypass", {31'd0, bus.instr_valid}, 32'd0);
    chk("second_req_addr", bus.imem_req_addr, 32'h4);
    cyc();
    chk("valid_2_after_acc", {31'd0, bus.instr_valid}, 32'd1);
    chk("head_pc0", bus.instr_pc, 32'h0);
    chk("head_instr0", bus.instr, 32'h1);
    chk("credit_stall", {31'd0, bus.imem_req_valid}, 32'd0);
    repeat (4) cyc();
    chk("accepts_at_cap", acc_log.size(), 32'd2);
    chk("acc0", acc_log[0], 32'h0);
    chk("acc1", acc_log[1], 32'h4);
    chk("cap_hold", {31'd0, bus.imem_req_valid}, 32'd0);
    expect_pop(32'h0);
    repeat (4) cyc();
    chk("one_refill", acc_log.size(), 32'd3);
    chk("acc2", acc_log[2], 32'h8);
    chk("refill_cap", {31'd0, bus.imem_req_valid}, 32'd0);
    expect_pop(32'h4);

    // Redirect with two requests in flight.
    quiesce(32'h80);
    lat = 3;
    base = acc_log.size();
    bus.imem_req_ready = 1'b1;
    n = 0;
    while (bus.imem_req_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("two_inflight", acc_log.size() - base, 32'd2);
    chk("no_rsp_yet", {31'd0, bus.imem_rsp_valid}, 32'd0);
    redirect(32'h100);
    expect_pop(32'h100);
    expect_pop(32'h104);
    chk("redir_acc0", acc_log[base+2], 32'h100);
    chk("redir_acc1", acc_log[base+3], 32'h104);

    // Redirect with coincident response and pop.
    quiesce(32'h200);
    lat = 2;
    bus.imem_req_ready = 1'b1;
    n = 0;
    while (!(bus.imem_rsp_valid && bus.instr_valid) && n < 20) begin
      cyc();
      n++;
    end
    chk("t4a_setup",
        {31'd0, bus.imem_rsp_valid && bus.instr_valid}, 32'd1);
    bus.instr_ready = 1'b1;
    redirect(32'h300);
    bus.instr_ready = 1'b0;
    chk("t4a_empty", {31'd0, bus.instr_valid}, 32'd0);
    chk("t4a_nop", bus.instr, 32'h0000_0013);
    expect_pop(32'h300);

    // Redirect with one response landing, one still in flight.
    quiesce(32'h400);
    lat = 3;
    base = acc_log.size();
    bus.imem_req_ready = 1'b1;
    n = 0;
    while (!bus.imem_rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("t4c_setup",
        {31'd0, bus.instr_valid || bus.imem_req_valid}, 32'd0);
    redirect(32'h500);
    expect_pop(32'h500);
    chk("t4c_acc", acc_log[base+2], 32'h500);

    // PC wrap at the top of the address space.
    quiesce(32'hFFFF_FFFC);
    lat = 1;
    base = acc_log.size();
    bus.imem_req_ready = 1'b1;
    expect_pop(32'hFFFF_FFFC);
    expect_pop(32'h0000_0000);
    chk("wrap_acc0", acc_log[base], 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log[base+1], 32'h0000_0000);

    // Misaligned redirect.
    quiesce(32'h600);
    base = acc_log.size();
    bus.imem_req_ready = 1'b1;
    redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    repeat (5) cyc();
    chk("fault_hold", {31'd0, fetch_fault}, 32'd1);
    chk("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("fault_no_acc", acc_log.size() - base, 32'd0);
    redirect(32'h200);
    chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
    expect_pop(32'h200);
    chk("fault_acc", acc_log[base], 32'h200);
`else
    expect_pop(32'h100);
    chk("align_acc", acc_log[base], 32'h100);
`endif

    bus.imem_req_ready = 1'b0;
    repeat (8) cyc();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
